// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage register file with a same-cycle read bypass,
// a forwarding tap, a sticky halt flag and a retired-instruction counter.
module wb_regfile #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             en,
   input  logic             valid,
   input  logic             RegWEN,
   input  logic [4:0]       Wsel,
   input  logic [1:0]       MemtoReg,
   input  logic [31:0]      portO,
   input  logic [31:0]      dmemLoad,
   input  logic [31:0]      pcp4,
   input  logic             HALT,
   input  logic [4:0]       rsel1,
   input  logic [4:0]       rsel2,
   output logic [31:0]      rdat1,
   output logic [31:0]      rdat2,
   output logic             fwd_valid,
   output logic [4:0]       fwd_sel,
   output logic [31:0]      fwd_data,
   output logic             halt_out,
   output logic [CNT_W-1:0] retired
);

   logic [31:0] regs [32];
   logic [31:0] wdat;
   logic        commit;
   logic        wr;

   // Reset suppresses commit so that no bypass or forward is visible while it is held.
   assign commit = en & valid & ~halt_out & ~RST;
   assign wr     = commit & RegWEN & (Wsel != 5'd0);

   // Writeback data select.
   always_comb begin
      // NOTE: assign a default before the case so every path drives wdat and no latch is inferred.
      wdat = portO;
      case (MemtoReg)
         2'b01:   wdat = dmemLoad;
         2'b10:   wdat = pcp4;
         default: wdat = portO;
      endcase
   end

   // Read port 1: zero register, then same-cycle bypass, then stored value.
   always_comb begin
      rdat1 = '0;
      if (rsel1 != 5'd0) begin
         if (wr && (Wsel == rsel1)) rdat1 = wdat;
         else                       rdat1 = regs[rsel1];
      end
   end

   // Read port 2: same priority as port 1, evaluated independently.
   always_comb begin
      rdat2 = '0;
      if (rsel2 != 5'd0) begin
         if (wr && (Wsel == rsel2)) rdat2 = wdat;
         else                       rdat2 = regs[rsel2];
      end
   end

   // Forwarding tap mirrors the write that will land on this edge.
   assign fwd_valid = wr;
   assign fwd_sel   = Wsel;
   assign fwd_data  = wdat;

   // Register array, halt flag and retired counter; reset wins over commit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         // NOTE: the architectural contract clears every register on reset, so the array is
         // reset here rather than left to power-up contents; entry 0 stays 0 forever.
         for (int i = 0; i < 32; i++) regs[i] <= '0;
         halt_out <= 1'b0;
         retired  <= '0;
      end else if (commit) begin
         // NOTE: non-blocking assignments keep all state updating from pre-edge values.
         if (wr)   regs[Wsel] <= wdat;
         if (HALT) halt_out   <= 1'b1;
         retired <= retired + CNT_W'(1);
      end
   end

endmodule
